// File: rtl/multi_edge_detector_pkg.sv
// rtl/multi_edge_detector_pkg.sv - shared state/mode encodings for the multi-channel edge detector
package multi_edge_detector_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_LOW  = 2'b01,
        ST_HIGH = 2'b10
    } chan_state_e;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } edge_mode_e;

    // Decides whether a detected transition is reported under the selected mode.
    function automatic logic mode_hit(input logic [1:0] mode, input logic rise, input logic fall);
        logic r_hit;
        r_hit = 1'b0;
        case (mode)
            MODE_RISE: r_hit = rise;
            MODE_FALL: r_hit = fall;
            MODE_BOTH: r_hit = rise | fall;
            default:   r_hit = 1'b0;
        endcase
        return r_hit;
    endfunction

endpackage

// File: rtl/multi_edge_detector_edge_chan.sv
// rtl/multi_edge_detector_edge_chan.sv - one channel: optional debounce (EDGE_DETECT_DEBOUNCE_EN), FSM, pulse, counter
module multi_edge_detector_edge_chan #(
    parameter int CNT_W = 8
`ifdef EDGE_DETECT_DEBOUNCE_EN
    , parameter int DEB_CYC = 3
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             clr_i,
    input  logic             in_i,
    output logic             hit_o,
    output logic             edge_o,
    output logic [CNT_W-1:0] cnt_o
);
    import multi_edge_detector_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic        w_lvl;
    logic        w_lvl_valid;
    chan_state_e r_state;
    chan_state_e w_state_nxt;
    logic        w_rise;
    logic        w_fall;
    logic        w_hit;
    logic        r_edge;
    logic [CNT_W-1:0] r_cnt;

`ifdef EDGE_DETECT_DEBOUNCE_EN
    localparam int RUN_W = $clog2(DEB_CYC + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEB_CYC);

    logic             r_cand;
    logic [RUN_W-1:0] r_run;
    logic             r_flvl;
    logic             r_fvalid;
    logic [RUN_W-1:0] w_run_nxt;
    logic             w_accept;

    // The level is accepted combinationally on the DEB_CYC-th equal sample so the FSM sees it that edge.
    always_comb begin
        w_run_nxt = RUN_W'(1);
        if (r_run != '0 && in_i == r_cand) begin
            w_run_nxt = (r_run == RUN_MAX) ? RUN_MAX : r_run + RUN_W'(1);
        end
        w_accept    = (w_run_nxt == RUN_MAX);
        w_lvl       = w_accept ? in_i : r_flvl;
        w_lvl_valid = w_accept | r_fvalid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cand   <= 1'b0;
            r_run    <= '0;
            r_flvl   <= 1'b0;
            r_fvalid <= 1'b0;
        end else if (!en_i) begin
            r_cand   <= 1'b0;
            r_run    <= '0;
            r_flvl   <= 1'b0;
            r_fvalid <= 1'b0;
        end else begin
            r_cand   <= in_i;
            r_run    <= w_run_nxt;
            r_flvl   <= w_lvl;
            r_fvalid <= w_lvl_valid;
        end
    end
`else
    always_comb begin
        w_lvl       = in_i;
        w_lvl_valid = 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        if (!en_i) begin
            w_state_nxt = ST_INIT;
        end else if (w_lvl_valid) begin
            case (r_state)
                ST_INIT: w_state_nxt = w_lvl ? ST_HIGH : ST_LOW;
                ST_LOW: begin
                    if (w_lvl) begin
                        w_state_nxt = ST_HIGH;
                        w_rise      = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!w_lvl) begin
                        w_state_nxt = ST_LOW;
                        w_fall      = 1'b1;
                    end
                end
                default: w_state_nxt = ST_INIT;
            endcase
        end
    end

    assign w_hit = mode_hit(mode_i, w_rise, w_fall);

    // Clear has priority over a coincident event so software sees a clean zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_edge <= w_hit;
            if (clr_i) begin
                r_cnt <= '0;
            end else if (w_hit && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign hit_o  = w_hit;
    assign edge_o = r_edge;
    assign cnt_o  = r_cnt;

endmodule

// File: rtl/multi_edge_detector.sv
// rtl/multi_edge_detector.sv - N-channel edge detector top; optional debounce via EDGE_DETECT_DEBOUNCE_EN
module multi_edge_detector #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
`ifdef EDGE_DETECT_DEBOUNCE_EN
    , parameter int DEB_CYC = 3
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic [1:0]            mode_i,
    input  logic                  clr_i,
    input  logic [N_CH-1:0]       in_i,
    output logic [N_CH-1:0]       edge_o,
    output logic                  any_edge_o,
    output logic [N_CH*CNT_W-1:0] cnt_o
);

    logic [N_CH-1:0] w_hit;
    logic            r_any;

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        multi_edge_detector_edge_chan #(
            .CNT_W   (CNT_W)
`ifdef EDGE_DETECT_DEBOUNCE_EN
            , .DEB_CYC (DEB_CYC)
`endif
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .en_i   (en_i),
            .mode_i (mode_i),
            .clr_i  (clr_i),
            .in_i   (in_i[k]),
            .hit_o  (w_hit[k]),
            .edge_o (edge_o[k]),
            .cnt_o  (cnt_o[k*CNT_W +: CNT_W])
        );
    end

    // Reduced from the pre-register hits so it lines up with edge_o in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_hit;
        end
    end

    assign any_edge_o = r_any;

endmodule

// File: tb/tb_multi_edge_detector.sv
// tb/tb_multi_edge_detector.sv - self-checking bench for multi_edge_detector
module tb_multi_edge_detector;
    import multi_edge_detector_pkg::*;

    localparam int N_CH = 4;
    localparam int DEB  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  mode;
    logic        clr;
    logic [3:0]  in;
    logic [3:0]  edge_a, edge_b;
    logic        any_a, any_b;
    logic [31:0] cnt_a;
    logic [7:0]  cnt_b;

    always #5 clk = ~clk;

    multi_edge_detector #(.N_CH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en_i(en), .mode_i(mode), .clr_i(clr), .in_i(in),
        .edge_o(edge_a), .any_edge_o(any_a), .cnt_o(cnt_a)
    );

    multi_edge_detector #(.N_CH(4), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .en_i(en), .mode_i(mode), .clr_i(clr), .in_i(in),
        .edge_o(edge_b), .any_edge_o(any_b), .cnt_o(cnt_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: each channel remembers the last accepted level since enable.
    bit   known [N_CH];
    bit   prev  [N_CH];
    bit   have  [N_CH];
    bit   flvl  [N_CH];
    int   m_cnt_a [N_CH];
    int   m_cnt_b [N_CH];
    logic [3:0] m_edge;
    bit   hist [N_CH][$];

    function automatic void model_reset();
        for (int k = 0; k < N_CH; k++) begin
            known[k] = 0; prev[k] = 0; have[k] = 0; flvl[k] = 0;
            m_cnt_a[k] = 0; m_cnt_b[k] = 0;
            hist[k].delete();
        end
        m_edge = '0;
    endfunction

    function automatic void model_step();
        bit hit;
        bit all_eq;
        for (int k = 0; k < N_CH; k++) begin
            hit = 0;
            if (!en) begin
                known[k] = 0; have[k] = 0;
                hist[k].delete();
            end else begin
`ifdef EDGE_DETECT_DEBOUNCE_EN
                hist[k].push_back(in[k]);
                if (hist[k].size() > DEB) void'(hist[k].pop_front());
                all_eq = (hist[k].size() == DEB);
                foreach (hist[k][j]) if (hist[k][j] != in[k]) all_eq = 0;
                if (all_eq) begin
                    have[k] = 1; flvl[k] = in[k];
                end
`else
                all_eq = 1;
                have[k] = all_eq; flvl[k] = in[k];
`endif
                if (have[k]) begin
                    if (known[k] && flvl[k] != prev[k]) begin
                        case (mode)
                            MODE_RISE: hit = flvl[k];
                            MODE_FALL: hit = !flvl[k];
                            MODE_BOTH: hit = 1;
                            default:   hit = 0;
                        endcase
                    end
                    known[k] = 1; prev[k] = flvl[k];
                end
            end
            m_edge[k] = hit;
            if (clr) begin
                m_cnt_a[k] = 0; m_cnt_b[k] = 0;
            end else if (hit) begin
                if (m_cnt_a[k] < 255) m_cnt_a[k]++;
                if (m_cnt_b[k] < 3)   m_cnt_b[k]++;
            end
        end
    endfunction

    function automatic logic [31:0] pack_a();
        logic [31:0] v = '0;
        for (int k = 0; k < N_CH; k++) v[k*8 +: 8] = 8'(m_cnt_a[k]);
        return v;
    endfunction

    function automatic logic [7:0] pack_b();
        logic [7:0] v = '0;
        for (int k = 0; k < N_CH; k++) v[k*2 +: 2] = 2'(m_cnt_b[k]);
        return v;
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input int i);
        chk($sformatf("rnd%0d_edge", i), 32'(edge_a), 32'(m_edge));
        chk($sformatf("rnd%0d_any", i), 32'(any_a), 32'(|m_edge));
        chk($sformatf("rnd%0d_cnt", i), cnt_a, pack_a());
        chk($sformatf("rnd%0d_edge_s", i), 32'(edge_b), 32'(m_edge));
        chk($sformatf("rnd%0d_cnt_s", i), 32'(cnt_b), 32'(pack_b()));
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic        clr;
        logic [3:0]  in;
        logic [3:0]  e_edge;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic [1:0] m, input logic c,
                                input logic [3:0] i, input logic [3:0] ee, input logic [31:0] ec);
        vec_t v;
        v.en = e; v.mode = m; v.clr = c; v.in = i; v.e_edge = ee; v.e_cnt = ec;
        return v;
    endfunction

    vec_t tbl [18];

    initial begin
        tbl[0]  = mk(1'b1, 2'b00, 1'b0, 4'b1111, 4'b0000, 32'h0000_0000);
        tbl[1]  = mk(1'b1, 2'b00, 1'b0, 4'b1111, 4'b0000, 32'h0000_0000);
        tbl[2]  = mk(1'b1, 2'b00, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000);
        tbl[3]  = mk(1'b1, 2'b00, 1'b0, 4'b0001, 4'b0001, 32'h0000_0001);
        tbl[4]  = mk(1'b1, 2'b00, 1'b0, 4'b0001, 4'b0000, 32'h0000_0001);
        tbl[5]  = mk(1'b1, 2'b00, 1'b0, 4'b0000, 4'b0000, 32'h0000_0001);
        tbl[6]  = mk(1'b1, 2'b10, 1'b0, 4'b0100, 4'b0100, 32'h0001_0001);
        tbl[7]  = mk(1'b1, 2'b10, 1'b0, 4'b0000, 4'b0100, 32'h0002_0001);
        tbl[8]  = mk(1'b1, 2'b10, 1'b0, 4'b0100, 4'b0100, 32'h0003_0001);
        tbl[9]  = mk(1'b1, 2'b10, 1'b0, 4'b0000, 4'b0100, 32'h0004_0001);
        tbl[10] = mk(1'b1, 2'b10, 1'b0, 4'b0100, 4'b0100, 32'h0005_0001);
        tbl[11] = mk(1'b1, 2'b10, 1'b0, 4'b0100, 4'b0000, 32'h0005_0001);
        tbl[12] = mk(1'b1, 2'b01, 1'b0, 4'b0000, 4'b0100, 32'h0006_0001);
        tbl[13] = mk(1'b1, 2'b11, 1'b0, 4'b0101, 4'b0000, 32'h0006_0001);
        tbl[14] = mk(1'b1, 2'b00, 1'b0, 4'b0101, 4'b0000, 32'h0006_0001);
        tbl[15] = mk(1'b1, 2'b00, 1'b0, 4'b0100, 4'b0000, 32'h0006_0001);
        tbl[16] = mk(1'b1, 2'b00, 1'b1, 4'b0101, 4'b0001, 32'h0000_0000);
        tbl[17] = mk(1'b1, 2'b00, 1'b0, 4'b0101, 4'b0000, 32'h0000_0000);

        reset = 1'b1; en = 1'b1; mode = 2'b00; clr = 1'b0; in = 4'b1111;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_edge", 32'(edge_a), 32'h0);
        chk("rst_any", 32'(any_a), 32'h0);
        chk("rst_cnt", cnt_a, 32'h0);
        chk("rst_cnt_s", 32'(cnt_b), 32'h0);
        reset = 1'b0;

`ifndef EDGE_DETECT_DEBOUNCE_EN
        for (int i = 0; i < 18; i++) begin
            en = tbl[i].en; mode = tbl[i].mode; clr = tbl[i].clr; in = tbl[i].in;
            cycle();
            chk($sformatf("tbl%0d_edge", i), 32'(edge_a), 32'(tbl[i].e_edge));
            chk($sformatf("tbl%0d_any", i), 32'(any_a), 32'(|tbl[i].e_edge));
            chk($sformatf("tbl%0d_cnt", i), cnt_a, tbl[i].e_cnt);
        end
        clr = 1'b0;

        // Five rising edges on ch1: wide counter reaches 5, 2-bit counter sticks at 3.
        for (int i = 0; i < 5; i++) begin
            in = 4'b0111; cycle();
            chk($sformatf("sat_rise%0d", i), 32'(edge_a), 32'h2);
            in = 4'b0101; cycle();
        end
        chk("sat_cnt", cnt_a, 32'h0000_0500);
        chk("sat_cnt_s", 32'(cnt_b), 32'h0C);

        // Disabled: toggling produces nothing and counts hold.
        en = 1'b0; mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            in = in ^ 4'b1010; cycle();
            chk($sformatf("dis%0d_edge", i), 32'(edge_a), 32'h0);
            chk($sformatf("dis%0d_cnt", i), cnt_a, 32'h0000_0500);
            chk($sformatf("dis%0d_cnt_s", i), 32'(cnt_b), 32'h0C);
        end
        en = 1'b1; in = 4'b1111; cycle();
        chk("reen_first", 32'(edge_a), 32'h0);
        cycle();
        chk("reen_second", 32'(edge_a), 32'h0);

        mode = 2'b00; in = 4'b1101; cycle();
        chk("pre_clr_fall", 32'(edge_a), 32'h0);
        in = 4'b1111; clr = 1'b1; cycle();
        chk("clr_edge", 32'(edge_a), 32'h2);
        chk("clr_cnt", cnt_a, 32'h0);
        chk("clr_cnt_s", 32'(cnt_b), 32'h0);
        clr = 1'b0;

        // Asynchronous reset in the middle of a pulse.
        in = 4'b1101; cycle();
        in = 4'b1111; cycle();
        chk("pulse_before_rst", 32'(edge_a), 32'h2);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_edge", 32'(edge_a), 32'h0);
        chk("rst_mid_any", 32'(any_a), 32'h0);
        chk("rst_mid_cnt", cnt_a, 32'h0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
`else
        // Debounce: 2-cycle glitch ignored, 3-cycle level yields one pulse.
        en = 1'b1; mode = 2'b00; in = 4'b0000;
        repeat (3) cycle();
        in = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk($sformatf("glitch%0d", i), 32'(edge_a), 32'h0);
        end
        in = 4'b0000; cycle();
        chk("glitch_end", 32'(edge_a), 32'h0);
        in = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk($sformatf("deb_wait%0d", i), 32'(edge_a), 32'h0);
        end
        cycle();
        chk("deb_pulse", 32'(edge_a), 32'h1);
        chk("deb_cnt", cnt_a, 32'h1);
        cycle();
        chk("deb_after", 32'(edge_a), 32'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom_range(0, 15) != 0);
            mode = 2'($urandom_range(0, 3));
            clr  = ($urandom_range(0, 511) == 0);
            in   = in ^ (4'($urandom) & 4'($urandom));
            cycle();
            check_model(i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
